// File: rtl/pio_input_conditioner.sv
// rtl/pio_input_conditioner.sv - read-back conditioning for the 6510 on-chip I/O port
//
// Purpose:
//   Produces the value a CPU read of the port register returns. Pins 0-5 are
//   synchronised and debounced. Pinless bits 6-7 emulate the slow capacitive
//   decay of a released output that was driving 1.
//
// Ports:
//   clock     in   1  system clock, rising edge
//   reset     in   1  synchronous, active-high reset
//   ce        in   1  one-cycle tick per CPU bus cycle; debounce/fade timebase
//   pio_in    in   6  raw asynchronous pin levels, bits 0-5
//   ddr       in   8  data-direction latch, 1 = output
//   data      in   8  output-data latch
//   port_read out  8  conditioned port-register read value
//   changed   out  1  one-clock pulse when port_read shows a new value

module pio_input_conditioner #(
  parameter int DEBOUNCE    = 4,
  parameter int FADE_CYCLES = 350000,
  parameter int FADE_WIDTH  = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [5:0] pio_in,
  input  logic [7:0] ddr,
  input  logic [7:0] data,
  output logic [7:0] port_read,
  output logic       changed
);

  localparam logic [7:0]            DEB_LAST  = 8'(DEBOUNCE - 1);
  localparam logic [FADE_WIDTH-1:0] FADE_LOAD = FADE_WIDTH'(FADE_CYCLES);
  localparam logic [FADE_WIDTH-1:0] FC_ONE    = {{(FADE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FADE_WIDTH-1:0] FC_ZERO   = '0;

  typedef enum logic [1:0] {
    ST_DRIVEN = 2'd0,
    ST_HOLD   = 2'd1,
    ST_FADED  = 2'd2
  } fade_state_t;

  // ------------------------------------------------------------------
  // Two-flop synchroniser. Pins idle high because of the pull-ups, so the
  // flops reset to 1 and do not fake a falling edge after reset.
  // ------------------------------------------------------------------
  logic [5:0] sync_meta;
  logic [5:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 6'h3F;
      sync_q    <= 6'h3F;
    end else begin
      sync_meta <= pio_in;
      sync_q    <= sync_meta;
    end
  end

  // ------------------------------------------------------------------
  // Debounce, one counter per pin. The counter counts consecutive ce ticks
  // on which the synchronised pin disagrees with the accepted level; any
  // agreeing tick throws the partial count away.
  // ------------------------------------------------------------------
  logic [5:0] stable_q;
  logic [5:0] stable_d;
  logic [7:0] cnt_q [6];
  logic [7:0] cnt_d [6];

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (ce) begin
      for (int i = 0; i < 6; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = sync_q[i];
          cnt_d[i]    = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q <= 6'h3F;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < 6; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Fade FSMs for bits 6 and 7 (index 0 -> bit 6, index 1 -> bit 7).
  // A released bit that was driving 1 keeps reading 1 for FADE_CYCLES
  // ticks; a released 0 reads 0 at once. Setting the DDR bit wins over
  // everything, including a tick in the same cycle.
  // ------------------------------------------------------------------
  fade_state_t           state_q [2];
  fade_state_t           state_d [2];
  logic [FADE_WIDTH-1:0] fc_q    [2];
  logic [FADE_WIDTH-1:0] fc_d    [2];
  logic [1:0]            q_q;
  logic [1:0]            q_d;
  logic [1:0]            fade_rd;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int j = 0; j < 2; j++) begin
        state_q[j] <= ST_FADED;
        fc_q[j]    <= FC_ZERO;
      end
      q_q <= 2'b00;
    end else begin
      for (int j = 0; j < 2; j++) begin
        state_q[j] <= state_d[j];
        fc_q[j]    <= fc_d[j];
      end
      q_q <= q_d;
    end
  end

  // Next-state logic
  always_comb begin
    q_d = q_q;
    for (int j = 0; j < 2; j++) begin
      state_d[j] = state_q[j];
      fc_d[j]    = fc_q[j];
      if (ddr[6+j]) begin
        state_d[j] = ST_DRIVEN;
        q_d[j]     = data[6+j];
      end else begin
        case (state_q[j])
          ST_DRIVEN: begin
            // The tick on the release edge is deliberately not counted:
            // the load value alone sets the hold length.
            if (q_q[j]) begin
              state_d[j] = ST_HOLD;
              fc_d[j]    = FADE_LOAD;
            end else begin
              state_d[j] = ST_FADED;
            end
          end
          ST_HOLD: begin
            if (ce) begin
              // <= guards the degenerate zero load as an immediate fade.
              if (fc_q[j] <= FC_ONE) begin
                state_d[j] = ST_FADED;
                fc_d[j]    = FC_ZERO;
                q_d[j]     = 1'b0;
              end else begin
                fc_d[j] = fc_q[j] - FC_ONE;
              end
            end
          end
          ST_FADED: begin
            q_d[j] = 1'b0;
          end
          default: begin
            state_d[j] = ST_FADED;
            fc_d[j]    = FC_ZERO;
            q_d[j]     = 1'b0;
          end
        endcase
      end
    end
  end

  // Output logic: the read bit is the next q, so port_read moves on the
  // same edge as the FSM.
  always_comb begin
    fade_rd = q_d;
  end

  // ------------------------------------------------------------------
  // Output register. Built from next-state values so that a direction or
  // data write appears after exactly one clock.
  // ------------------------------------------------------------------
  logic [5:0] pin_rd;
  logic [7:0] read_d;

  always_comb begin
    pin_rd = (ddr[5:0] & data[5:0]) | (~ddr[5:0] & stable_d);
    read_d = {fade_rd, pin_rd};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      port_read <= 8'h3F;
      changed   <= 1'b0;
    end else begin
      port_read <= read_d;
      changed   <= (read_d != port_read);
    end
  end

endmodule

// File: tb/tb_pio_input_conditioner.sv
// tb/tb_pio_input_conditioner.sv - randomized and directed bench for pio_input_conditioner

module tb_pio_input_conditioner;

  localparam int DEB  = 4;
  localparam int FADE = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce    = 1'b1;
  logic [5:0] pio_in = 6'h3F;
  logic [7:0] ddr   = 8'h00;
  logic [7:0] data  = 8'h00;
  logic [7:0] port_read;
  logic       changed;

  int passed = 0;
  int total  = 0;
  bit check_en = 1'b0;

  pio_input_conditioner #(
    .DEBOUNCE(DEB),
    .FADE_CYCLES(FADE),
    .FADE_WIDTH(20)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ce(ce),
    .pio_in(pio_in),
    .ddr(ddr),
    .data(data),
    .port_read(port_read),
    .changed(changed)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: pins settle after DEB consecutive disagreeing ticks
  // seen two clocks late; a released high bit 6/7 survives FADE ticks.
  logic [5:0] m_s1, m_s2, m_stable;
  int         m_run [6];
  bit [1:0]   m_drv, m_hold, m_q;
  int         m_el [2];
  logic [7:0] m_port, m_nxt;
  logic       m_chg;

  always @(posedge clock) begin
    if (reset) begin
      m_s1 = 6'h3F; m_s2 = 6'h3F; m_stable = 6'h3F;
      for (int i = 0; i < 6; i++) m_run[i] = 0;
      m_drv = 0; m_hold = 0; m_q = 0;
      m_el[0] = 0; m_el[1] = 0;
      m_port = 8'h3F; m_chg = 1'b0;
    end else begin
      if (ce) begin
        for (int i = 0; i < 6; i++) begin
          if (m_s2[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_stable[i] = m_s2[i];
              m_run[i] = 0;
            end
          end else m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = pio_in;
      for (int j = 0; j < 2; j++) begin
        if (ddr[6+j]) begin
          m_drv[j] = 1; m_hold[j] = 0; m_q[j] = data[6+j];
        end else if (m_drv[j]) begin
          m_drv[j] = 0; m_hold[j] = m_q[j]; m_el[j] = 0;
        end else if (m_hold[j] && ce) begin
          m_el[j]++;
          if (m_el[j] == FADE) begin
            m_hold[j] = 0; m_q[j] = 0;
          end
        end
      end
      m_nxt = {m_q[1], m_q[0], (ddr[5:0] & data[5:0]) | (~ddr[5:0] & m_stable)};
      m_chg = (m_nxt != m_port);
      m_port = m_nxt;
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check("model_port_read", port_read, m_port);
      check("model_changed", {7'd0, changed}, {7'd0, m_chg});
    end
  end

  int pulses;

  initial begin
    // Test 1: reset and idle
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_en = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_port_read", port_read, 8'h3F);
    check("idle_changed", {7'd0, changed}, 8'h00);

    // Test 2: debounced falling edge on pin 0, then release, then glitch
    pio_in = 6'h3E;
    repeat (5) @(negedge clock);
    check("deb_before", port_read, 8'h3F);
    @(negedge clock);
    check("deb_at6", port_read, 8'h3E);
    check("deb_at6_changed", {7'd0, changed}, 8'h01);
    @(negedge clock);
    check("deb_pulse_single", {7'd0, changed}, 8'h00);
    pio_in = 6'h3F;
    repeat (8) @(negedge clock);
    check("deb_back_high", port_read, 8'h3F);
    pio_in = 6'h3E;
    repeat (3) @(negedge clock);
    pio_in = 6'h3F;
    repeat (10) @(negedge clock);
    check("glitch_rejected", port_read, 8'h3F);

    // Test 3: drive then release
    ddr = 8'hFF; data = 8'hA5;
    @(negedge clock);
    check("drive_a5", port_read, 8'hA5);
    ddr = 8'h00;
    @(negedge clock);
    check("release_bf", port_read, 8'hBF);

    // Test 4: fade after FADE ticks, then abort at tick 10
    repeat (FADE - 1) @(negedge clock);
    check("fade_tick15", port_read, 8'hBF);
    @(negedge clock);
    check("fade_tick16", port_read, 8'h3F);
    check("fade_changed", {7'd0, changed}, 8'h01);
    ddr = 8'hFF; data = 8'h80;
    @(negedge clock);
    ddr = 8'h00;
    @(negedge clock);
    check("rerelease_bf", port_read, 8'hBF);
    repeat (9) @(negedge clock);
    ddr = 8'h80; data = 8'h00;
    @(negedge clock);
    check("abort_follow0", port_read, 8'h3F);
    data = 8'h80;
    @(negedge clock);
    check("abort_follow1", port_read, 8'hBF);
    ddr = 8'h00;
    repeat (FADE + 4) @(negedge clock);
    check("abort_refade", port_read, 8'h3F);

    // Test 5: released 0 on bit 6 stays 0
    ddr = 8'h40; data = 8'h00;
    @(negedge clock);
    ddr = 8'h00;
    for (int k = 0; k < 2 * FADE; k++) begin
      @(negedge clock);
      check("bit6_low", {7'd0, port_read[6]}, 8'h00);
    end

    // Freeze with ce low
    ce = 1'b0; pio_in = 6'h3B;
    repeat (20) @(negedge clock);
    check("freeze_hold", port_read, 8'h3F);
    ce = 1'b1;
    repeat (4) @(negedge clock);
    check("freeze_release", port_read, 8'h3B);
    pio_in = 6'h3F;
    repeat (10) @(negedge clock);

    // Test 6: reset mid-fade and mid-debounce
    ddr = 8'hC0; data = 8'hC0;
    @(negedge clock);
    ddr = 8'h00;
    repeat (5) @(negedge clock);
    pio_in = 6'h3D;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_port", port_read, 8'h3F);
    check("reset_changed", {7'd0, changed}, 8'h00);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (changed) pulses++;
    end
    check("post_reset_pulses", 8'(pulses), 8'd1);
    check("post_reset_port", port_read, 8'h3D);
    pio_in = 6'h3F;
    repeat (10) @(negedge clock);

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      ce = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) pio_in = pio_in ^ (6'b1 << $urandom_range(0, 5));
      if ($urandom_range(0, 59) == 0) ddr = 8'($urandom);
      if ($urandom_range(0, 9) == 0) data = 8'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clock);
    end
    reset = 1'b0;
    @(negedge clock);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pio_input_conditioner.md
# pio_input_conditioner

Conditions the read-back path of the 6510 on-chip I/O port. It sits between the external `pio` pins plus the port's DDR/data latches and the CPU read mux for address $0000/$0001. It synchronises and debounces the six pin inputs (bits 0-5). It also emulates the capacitive "fade" of the two pinless bits (6-7) after they are switched to input. The registered 8-bit `port_read` value is what a read of the port register returns.

## Interface
Parameters:
- `DEBOUNCE`, 4: consecutive `ce` ticks a synchronised pin must differ from its stable value before the stable value updates (range 1-255).
- `FADE_CYCLES`, 350000: `ce` ticks a released bit 6/7 holds a 1 before reading 0 (range 1 to 2^`FADE_WIDTH`-1).
- `FADE_WIDTH`, 20: width of each fade counter.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ce`  in  1  one-cycle tick per CPU bus cycle (phi2); the debounce and fade timebase.
- `pio_in`  in  6  raw pin levels of port bits 0-5, asynchronous.
- `ddr`  in  8  port data-direction latch; 1 = output.
- `data`  in  8  port output-data latch.
- `port_read`  out  8  conditioned value returned on a port-register read.
- `changed`  out  1  one-`clock` pulse in the cycle `port_read` first shows a new value.

## Operation
- Synchronizer:
  - Two flip-flops per bit on `pio_in`, clocked every `clock`, not gated by `ce`.
  - Reset value 1 (pins are pulled up).
- Debounce, one per bit 0-5:
  - Holds `stable[i]` and a counter `cnt[i]`, both evaluated only when `ce`=1.
  - If `sync[i]`==`stable[i]`, then `cnt[i]`<=0.
  - Else, if `cnt[i]`==`DEBOUNCE`-1, then `stable[i]`<=`sync[i]` and `cnt[i]`<=0.
  - Else `cnt[i]`<=`cnt[i]`+1.
  - A mismatch interrupted by one matching tick restarts the count from 0.
- Bits 0-5 read value: `ddr[i]` ? `data[i]` : `stable[i]`.
- Fade FSM, one per bit 6-7. States are DRIVEN, HOLD and FADED, with a fade counter `fc` and a read bit `q`:
  - Any state, `ddr[i]`=1: go to DRIVEN, `q`<=`data[i]`. This rule takes priority over everything else, including a `ce` in the same cycle.
  - DRIVEN, `ddr[i]`=0, `q`=1: go to HOLD, `fc`<=`FADE_CYCLES`, `q` stays 1.
  - DRIVEN, `ddr[i]`=0, `q`=0: go to FADED.
  - HOLD, `ce`=1, `fc`==1: go to FADED, `q`<=0.
  - HOLD, `ce`=1, `fc`>1: `fc`<=`fc`-1.
  - HOLD, `ce`=0: no change.
  - While in HOLD or FADED, changes on `data[i]` are ignored.
  - FADED holds `q`=0.
- Bits 6-7 read value: `q`.
- Output register:
  - `port_read` is updated every `clock` from the next-state values of `stable` and `q`, so the register and its source change on the same edge.
  - `changed` <= (new `port_read` != current `port_read`).
- Reset values:
  - Synchronizer flops: all 1.
  - `stable`: 6'h3F.
  - `cnt` and `fc`: 0.
  - Fade FSMs: FADED with `q`=0.
  - `port_read`: 8'h3F.
  - `changed`: 0.
- A `reset` asserted mid-debounce or mid-fade abandons the operation; the first post-reset cycle sees the reset values.

## Timing
- Latency from `ddr`/`data` to `port_read`, bits 0-5 and the DRIVEN case of 6-7: 1 `clock`.
- Latency from a `pio_in` edge to `port_read`:
  - 2 `clock` for synchronisation.
  - Then the edge on which the `DEBOUNCE`-th consecutive mismatching `ce` tick is sampled.
  - Minimum total with `ce` held at 1: 2+`DEBOUNCE` clocks.
- Fade: bit 6/7 reads 0 on the edge that samples the `FADE_CYCLES`-th `ce` tick after the DRIVEN->HOLD edge. A `ce` on the release edge itself is not counted.
- `changed` is high for exactly the one `clock` in which `port_read` holds its new value. It is never stretched; back-to-back changes give back-to-back pulses.
- With `ce` held at 0, debounce and fade freeze. The synchronizer and the `ddr`/`data` paths stay live.

## Test plan
1. Reset, then `ddr`=0 and `pio_in`=6'h3F: `port_read`=8'h3F and `changed`=0 on every cycle.
2. `ce`=1 constantly, `DEBOUNCE`=4, `pio_in[0]` goes 1->0: `port_read`=8'h3E exactly 6 clocks later, with a single `changed` pulse on that cycle. A glitch on `pio_in[0]` of 3 clocks produces no change at all.
3. `ddr`=8'hFF, `data`=8'hA5: `port_read`=8'hA5 one clock later. Then `ddr`=8'h00 with `pio_in`=6'h3F: `port_read`=8'hBF, with bit 7 held.
4. Continue test 3 with `FADE_CYCLES`=16 and `ce`=1: bit 7 drops to give `port_read`=8'h3F on the 16th tick. Re-setting `ddr[7]`=1 at tick 10 aborts the fade, and the bit follows `data[7]` one clock later.
5. Release bit 6 with `data[6]`=0: it reads 0 immediately and stays 0 for 2×`FADE_CYCLES` ticks.
6. Assert `reset` for one clock mid-fade and mid-debounce: the next cycle shows `port_read`=8'h3F, `changed` pulses once, and all counters restart from 0.
